sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Single-clock, parametrised successor of the dual-clock sample FIFO used between filter stages. It buffers signed samples between the up-sampler and the downstream filter chain when both run on one clock. It adds an explicit fill level, programmable almost-full/almost-empty thresholds, synchronous flush, overflow/underflow pulses and an optional first-word-fall-through (FWFT) read mode.

## Interface
- DATA_WIDTH, 16, sample width in bits (signed)
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_WIDTH (localparam), $clog2(DEPTH), pointer index width; pointers carry one extra wrap bit
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- din  in  DATA_WIDTH  signed write data
- wr_en  in  1  write request
- rd_en  in  1  read request (pop)
- flush  in  1  synchronous clear
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold
- dout  out  DATA_WIDTH  signed read data
- full, empty  out  1  level == DEPTH / level == 0
- almost_full  out  1  level ≥ af_thresh
- almost_empty  out  1  level ≤ ae_thresh
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- wr_ack, rd_ack  out  1  registered accept indications
- overflow, underflow  out  1  registered reject pulses

## Operation
- Reset (rst_n=0): pointers, level, dout, wr_ack, rd_ack, overflow and underflow go to 0. Flags follow from level=0: empty=1, full=0, almost_empty=1, almost_full=(af_thresh==0). Memory contents are not reset.
- Write is accepted when wr_en && !full && !flush. The sample is stored at wr_ptr and wr_ptr increments.
- Read is accepted when rd_en && !empty && !flush. In standard mode, dout loads mem[rd_ptr] and rd_ptr increments.
- Full/empty are evaluated on pre-edge state:
  - simultaneous wr_en and rd_en at full: only the read is accepted; overflow pulses.
  - simultaneous wr_en and rd_en at empty: only the write is accepted; underflow pulses.
  - otherwise both are accepted and level is unchanged.
- level is registered: +1 on write only, −1 on read only, unchanged on both or neither. full, empty, almost_full and almost_empty are combinational from level and the thresholds.
- Pointer wrap: index bits wrap modulo DEPTH, and the extra bit toggles on wrap. level always equals wr_ptr − rd_ptr modulo 2·DEPTH.
- Rejected write (wr_en && full && !flush): overflow=1 for one cycle and memory is unchanged. Rejected read (rd_en && empty && !flush): underflow=1 for one cycle and dout holds its value.
- Flush has priority over wr_en and rd_en. It clears the pointers, level and dout to 0. No ack or error pulses are generated in the flush cycle.
- Thresholds are sampled combinationally and may change at any time. Threshold values above DEPTH make almost_full constantly 0.

## Timing
- Write accepted at edge N: level and flags update after edge N. wr_ack=1 during cycle N+1 only.
- Read accepted at edge N (standard mode): dout is valid after edge N and held until the next accepted read or flush. rd_ack=1 during cycle N+1.
- overflow and underflow are high for exactly the cycle after the offending edge.
- Back-to-back operation is sustained at one write and one read per cycle indefinitely.
- Reset asserted mid-operation: all outputs reach their reset values immediately, without waiting for a clock edge. The first accepted write after release lands at address 0.

## Configuration
- FIFO_FWFT_EN defined:
  - dout = empty ? 0 : mem[rd_ptr], combinationally. The head word appears the cycle after it is written into an empty FIFO, with no rd_en needed.
  - An accepted read pops the entry, and dout shows the next entry (or 0) after the edge.
  - rd_ack, underflow and all flag timing are unchanged.
- FIFO_FWFT_EN undefined: standard registered read as described under Operation.

## Test plan
- DATA_WIDTH=16, DEPTH=8: after reset, write 0x0001..0x0008. Required: level=8 and full=1 after the 8th edge. A 9th write of 0x0009 gives overflow=1 for one cycle, wr_ack=0 and level stays 8.
- Read 8 times. Required: dout=1..8 in order and empty=1 after the 8th read. A 9th read gives underflow=1 and dout holds 0x0008.
- Simultaneous wr/rd:
  - at level 3: level stays 3, and wr_ack and rd_ack are both 1;
  - at level 0: level goes to 1, rd_ack=0, underflow=1;
  - at level 8: level goes to 7, wr_ack=0, overflow=1.
- af_thresh=6, ae_thresh=2, writing from empty: almost_empty falls after the 3rd write and almost_full rises after the 6th. Reading back down, almost_full falls at level 5 and almost_empty rises at level 2.
- At level 5, assert flush with wr_en=1 and rd_en=1. Required: level=0, empty=1, dout=0, no acks.
- Pointer wrap and signed data:
  - 20 cycles of simultaneous write/read, starting at level 2, with data including 0x8000 (−32768) and 0x7FFF. Required: data is exact and in order across the wrap.
  - With FIFO_FWFT_EN, writing 0x1234 into an empty FIFO gives dout=0x1234 the next cycle with rd_en=0.

Source files
------------

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - write/read handshake, thresholds and status bundle for sync_fifo_prog
//
// Parameters: DATA_WIDTH (sample width), DEPTH (entries, power of two).
// master : drives din, wr_en, rd_en, flush, af_thresh, ae_thresh
// slave  : drives dout, full, empty, almost_full, almost_empty, level,
//          wr_ack, rd_ack, overflow, underflow
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic signed [DATA_WIDTH-1:0] din;
  logic                         wr_en;
  logic                         rd_en;
  logic                         flush;
  logic [ADDR_WIDTH:0]          af_thresh;
  logic [ADDR_WIDTH:0]          ae_thresh;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         full;
  logic                         empty;
  logic                         almost_full;
  logic                         almost_empty;
  logic [ADDR_WIDTH:0]          level;
  logic                         wr_ack;
  logic                         rd_ack;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output din, wr_en, rd_en, flush, af_thresh, ae_thresh,
    input  dout, full, empty, almost_full, almost_empty, level,
           wr_ack, rd_ack, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, flush, af_thresh, ae_thresh,
    output dout, full, empty, almost_full, almost_empty, level,
           wr_ack, rd_ack, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock signed sample FIFO with level, thresholds, flush and error pulses
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_prog_if.slave (write/read requests, flush, thresholds in;
//           data, flags, level, acks and overflow/underflow pulses out)
// Optional build macro: FIFO_FWFT_EN selects first-word-fall-through read data;
// when undefined, dout is registered on each accepted read.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_prog_if.slave    bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one wrap bit above the index so that full (DEPTH) and
  // empty (0) occupancy remain distinguishable in their difference.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] level_c;
  logic                full_c;
  logic                empty_c;
  logic                wr_acc;
  logic                rd_acc;
  logic                wr_ack_q;
  logic                rd_ack_q;
  logic                overflow_q;
  logic                underflow_q;

  // Occupancy is the modulo-2*DEPTH pointer distance; it is a pure function
  // of registered state, so it changes only after a clock edge.
  assign level_c = wr_ptr - rd_ptr;
  assign full_c  = (level_c == FULL_LEVEL);
  assign empty_c = (level_c == '0);

  // Acceptance uses pre-edge flags: at full only a read can go through,
  // at empty only a write can.
  assign wr_acc = bus.wr_en && !full_c  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty_c && !bus.flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.din;
    end
  end

`ifdef FIFO_FWFT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc;
      rd_ack_q    <= rd_acc;
      overflow_q  <= bus.wr_en && full_c;
      underflow_q <= bus.rd_en && empty_c;
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Head word is visible combinationally; an empty FIFO shows zero.
  assign bus.dout = empty_c ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
  logic signed [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dout_q      <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dout_q      <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc;
      rd_ack_q    <= rd_acc;
      overflow_q  <= bus.wr_en && full_c;
      underflow_q <= bus.rd_en && empty_c;
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // dout holds the last popped sample until the next accepted read or flush.
  assign bus.dout = dout_q;
`endif

  assign bus.level        = level_c;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  // Thresholds above DEPTH can never be reached, so almost_full stays low.
  assign bus.almost_full  = (level_c >= bus.af_thresh);
  assign bus.almost_empty = (level_c <= bus.ae_thresh);
  assign bus.wr_ack       = wr_ack_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - self-checking scoreboard bench for sync_fifo_prog
module tb_sync_fifo_prog;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Bench model of the FIFO.
  int            m_level = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_dout = '0;
  logic          e_wr_ack, e_rd_ack, e_ovf, e_udf;
  logic [DW-1:0] exp_pop;
  logic [DW-1:0] rd_data;

  // Drive one cycle of stimulus, advance the model, sample outputs #1 after the edge.
  task automatic drive(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    logic [DW-1:0] pre;
    bus.wr_en = w; bus.rd_en = r; bus.flush = f; bus.din = d;
    #1;
    pre      = bus.dout;
    e_wr_ack = w && !f && (m_level != DEPTH);
    e_rd_ack = r && !f && (m_level != 0);
    e_ovf    = w && !f && (m_level == DEPTH);
    e_udf    = r && !f && (m_level == 0);
    exp_pop  = 'x;
    if (f) begin
      m_level = 0; sb.delete(); m_dout = '0;
    end else begin
      if (e_rd_ack) begin exp_pop = sb.pop_front(); m_dout = exp_pop; end
      if (e_wr_ack) sb.push_back(d);
      m_level = m_level + int'(e_wr_ack) - int'(e_rd_ack);
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0;
`ifdef FIFO_FWFT_EN
    rd_data = pre;
`else
    rd_data = bus.dout;
`endif
  endtask

  task automatic test_reset();
    checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", bus.empty, bus.full); end
    checks++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b1) begin errors++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=1", bus.almost_empty, bus.almost_full); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
    checks++; if ({bus.wr_ack, bus.rd_ack, bus.overflow, bus.underflow} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {bus.wr_ack, bus.rd_ack, bus.overflow, bus.underflow}); end
  endtask

  task automatic test_fill_overflow();
    bus.af_thresh = 4'd9;  // unreachable threshold
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(i));
      checks++; if (bus.wr_ack !== 1'b1 || bus.level !== 4'(i)) begin errors++; $display("FAIL fill_%0d got ack=%b level=%0d exp ack=1 level=%0d", i, bus.wr_ack, bus.level, i); end
    end
    checks++; if (bus.full !== 1'b1 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b af=%b exp full=1 af=0", bus.full, bus.almost_full); end
    drive(1'b1, 1'b0, 1'b0, 16'h0009);
    checks++; if (bus.overflow !== 1'b1 || bus.wr_ack !== 1'b0 || bus.level !== 4'd8) begin errors++; $display("FAIL overflow got ovf=%b ack=%b level=%0d exp ovf=1 ack=0 level=8", bus.overflow, bus.wr_ack, bus.level); end
    drive(1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      checks++; if (rd_data !== exp_pop || exp_pop !== DW'(i) || bus.rd_ack !== 1'b1) begin errors++; $display("FAIL drain_%0d got data=%h ack=%b exp data=%h ack=1", i, rd_data, bus.rd_ack, exp_pop); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.underflow !== 1'b1 || bus.rd_ack !== 1'b0) begin errors++; $display("FAIL underflow got udf=%b ack=%b exp udf=1 ack=0", bus.underflow, bus.rd_ack); end
`ifdef FIFO_FWFT_EN
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL underflow_dout got=%h exp=0000", bus.dout); end
`else
    checks++; if (bus.dout !== 16'h0008) begin errors++; $display("FAIL underflow_dout got=%h exp=0008", bus.dout); end
`endif
    drive(1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, DW'(16'h0010 + i));
    drive(1'b1, 1'b1, 1'b0, 16'h0013);
    checks++; if (bus.level !== 4'd3 || bus.wr_ack !== 1'b1 || bus.rd_ack !== 1'b1 || rd_data !== 16'h0010) begin errors++; $display("FAIL simul_l3 got level=%0d wa=%b ra=%b data=%h exp 3 1 1 0010", bus.level, bus.wr_ack, bus.rd_ack, rd_data); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      checks++; if (rd_data !== exp_pop) begin errors++; $display("FAIL simul_drain got=%h exp=%h", rd_data, exp_pop); end
    end
    drive(1'b1, 1'b1, 1'b0, 16'h0020);
    checks++; if (bus.level !== 4'd1 || bus.rd_ack !== 1'b0 || bus.underflow !== 1'b1 || bus.wr_ack !== 1'b1) begin errors++; $display("FAIL simul_l0 got level=%0d ra=%b udf=%b wa=%b exp 1 0 1 1", bus.level, bus.rd_ack, bus.underflow, bus.wr_ack); end
    for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 1'b0, DW'(16'h0020 + i));
    drive(1'b1, 1'b1, 1'b0, 16'h0099);
    checks++; if (bus.level !== 4'd7 || bus.wr_ack !== 1'b0 || bus.overflow !== 1'b1 || rd_data !== 16'h0020) begin errors++; $display("FAIL simul_l8 got level=%0d wa=%b ovf=%b data=%h exp 7 0 1 0020", bus.level, bus.wr_ack, bus.overflow, rd_data); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      checks++; if (rd_data !== exp_pop || exp_pop !== DW'(16'h0021 + i)) begin errors++; $display("FAIL simul_tail_%0d got=%h exp=%h", i, rd_data, 16'h0021 + i); end
    end
  endtask

  task automatic test_thresholds();
    bus.af_thresh = 4'd6; bus.ae_thresh = 4'd2;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(16'h0100 + k));
      checks++; if (bus.almost_empty !== (k <= 2) || bus.almost_full !== (k >= 6)) begin errors++; $display("FAIL thr_up_%0d got ae=%b af=%b exp ae=%b af=%b", k, bus.almost_empty, bus.almost_full, k <= 2, k >= 6); end
    end
    for (int k = 5; k >= 2; k--) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      checks++; if (bus.almost_full !== 1'b0 || bus.almost_empty !== (k <= 2) || rd_data !== exp_pop) begin errors++; $display("FAIL thr_down_%0d got af=%b ae=%b data=%h exp af=0 ae=%b data=%h", k, bus.almost_full, bus.almost_empty, rd_data, k <= 2, exp_pop); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, DW'(16'h0200 + i));
    checks++; if (bus.level !== 4'd5) begin errors++; $display("FAIL flush_pre got=%0d exp=5", bus.level); end
    drive(1'b1, 1'b1, 1'b1, 16'h0bad);
    checks++; if (bus.level !== 4'd0 || bus.empty !== 1'b1 || bus.dout !== 16'h0000) begin errors++; $display("FAIL flush got level=%0d empty=%b dout=%h exp 0 1 0000", bus.level, bus.empty, bus.dout); end
    checks++; if ({bus.wr_ack, bus.rd_ack, bus.overflow, bus.underflow} !== 4'b0000) begin errors++; $display("FAIL flush_pulses got=%b exp=0000", {bus.wr_ack, bus.rd_ack, bus.overflow, bus.underflow}); end
  endtask

  task automatic test_wrap_signed();
    logic [DW-1:0] d;
    drive(1'b1, 1'b0, 1'b0, 16'h8000);
    drive(1'b1, 1'b0, 1'b0, 16'h7fff);
    for (int i = 0; i < 20; i++) begin
      d = (i % 5 == 0) ? 16'h8000 : (i % 5 == 1) ? 16'h7fff : DW'($urandom);
      drive(1'b1, 1'b1, 1'b0, d);
      checks++; if (rd_data !== exp_pop || bus.level !== 4'd2) begin errors++; $display("FAIL wrap_%0d got data=%h level=%0d exp data=%h level=2", i, rd_data, bus.level, exp_pop); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      checks++; if (rd_data !== exp_pop) begin errors++; $display("FAIL wrap_tail got=%h exp=%h", rd_data, exp_pop); end
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    drive(1'b1, 1'b0, 1'b0, 16'h1234);
    checks++; if (bus.dout !== 16'h1234) begin errors++; $display("FAIL fwft_head got=%h exp=1234", bus.dout); end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (rd_data !== 16'h1234 || bus.dout !== 16'h0000) begin errors++; $display("FAIL fwft_pop got pre=%h post=%h exp 1234 0000", rd_data, bus.dout); end
  endtask
`endif

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0301);
    drive(1'b1, 1'b0, 1'b0, 16'h0302);
    #1 rst_n = 1'b0;  // mid-cycle, away from any edge
    #1;
    checks++; if (bus.level !== 4'd0 || bus.empty !== 1'b1 || bus.wr_ack !== 1'b0) begin errors++; $display("FAIL async_reset got level=%0d empty=%b wa=%b exp 0 1 0", bus.level, bus.empty, bus.wr_ack); end
    m_level = 0; sb.delete(); m_dout = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 16'habcd);
    checks++; if (dut.mem[0] !== 16'habcd) begin errors++; $display("FAIL reset_addr0 got=%h exp=abcd", dut.mem[0]); end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (rd_data !== 16'habcd) begin errors++; $display("FAIL reset_read got=%h exp=abcd", rd_data); end
  endtask

  initial begin
    bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    bus.af_thresh = 4'd0; bus.ae_thresh = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_thresholds();
    test_flush();
    test_wrap_signed();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
